// File: rtl/multicycle_main_fsm.sv
// Multicycle main control FSM: sequences FETCH/DECODE/execute states with a memory handshake, watchdog and illegal-opcode trap.
// Optional retired-instruction counter enabled by defining MC_RETIRE_CNT_EN.
module multicycle_main_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_retired
`endif
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  EXECUTE = 4'd6, ALUWB  = 4'd7,
    BRANCH  = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'(TIMEOUT);

  state_t         state, state_nx;
  logic [WCW-1:0] wait_cnt;
  logic           is_wait;
  logic           timeout_hit;

  assign is_wait     = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // A ready on the expiring cycle completes normally, so only a not-ready cycle can trip.
  assign timeout_hit = (TIMEOUT > 0) && is_wait && !mem_ready && (wait_cnt == WLIM - WCW'(1));

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (mem_ready) state_nx = DECODE;
      DECODE: begin
        case (Opcode)
          6'b100011, 6'b101011: state_nx = MEMADR;
          6'b000000:            state_nx = EXECUTE;
          6'b000100:            state_nx = BRANCH;
          6'b001000:            state_nx = ADDIEX;
          6'b000010:            state_nx = JUMP;
          default:              state_nx = ILLEGAL;
        endcase
      end
      MEMADR:  state_nx = (Opcode == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_nx = MEMWB;
      MEMWR:   if (mem_ready) state_nx = FETCH;
      EXECUTE: state_nx = ALUWB;
      ADDIEX:  state_nx = ADDIWB;
      default: state_nx = FETCH;
    endcase
    if (timeout_hit) state_nx = FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (timeout_hit || !is_wait || (state_nx != state))
        wait_cnt <= '0;
      else if (!mem_ready && (wait_cnt != WLIM))
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Outputs are decoded from state and forced low while reset is held.
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    bus_err    = timeout_hit;
    state_dbg  = state;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
      state_dbg  = 4'd0;
    end
  end

`ifdef MC_RETIRE_CNT_EN
  logic retire_evt;
  assign retire_evt = (state == MEMWB) || (state == ALUWB) || (state == ADDIWB) ||
                      (state == BRANCH) || (state == JUMP) || ((state == MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_retired <= '0;
    else if (retire_evt) instr_retired <= instr_retired + CNT_W'(1);
  end
`endif

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Multicycle successor to the single-cycle main decoder; sits in the Control Unit and drives the multicycle datapath (IR, A/B, ALUOut, MDR registers).
- Sequences each instruction through FETCH/DECODE/execute states, with a mem_req/mem_ready handshake for variable-latency unified memory.
- Adds a bus-timeout watchdog and an illegal-opcode trap.
- Its ALUOp output feeds the existing ALU decoder unchanged.

Parameters:
- TIMEOUT, 16, consecutive not-ready cycles before a memory access is abandoned; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  6  instr[31:26] from IR; stable after DECODE.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  write strobe, valid while mem_req=1.
- IRWrite  out  1  IR load enable.
- PCWrite  out  1  unconditional PC write enable.
- Branch  out  1  conditional PC write, ANDed with Zero outside.
- PCSrc  out  2  00=ALU, 01=ALUOut, 10=jump target.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- ALUOp  out  2  to ALU decoder: 00 add, 01 sub, 10 funct.
- RegDst  out  1  0=rt, 1=rd.
- MemtoReg  out  1  0=ALUOut, 1=MDR.
- RegWrite  out  1  register file write enable.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- bus_err  out  1  one-cycle pulse on watchdog expiry.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset and output style:
  - rst_n low: state=FETCH, wait_cnt=0, every output forced 0 (combinational gating), state_dbg=0.
  - Outputs are Moore, decoded from state. Exception: IRWrite/PCWrite in FETCH are qualified by mem_ready. Every output not listed for a state is 0.
- State encodings and outputs:
  - FETCH(0): mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. If mem_ready: IRWrite=PCWrite=1, go to DECODE. Else stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Opcode:
    - 100011/101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other -> ILLEGAL
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
  - MEMRD(3): mem_req=1, IorD=1. On mem_ready -> MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(5): mem_req=1, IorD=1, MemWrite=1, held for the whole wait. On mem_ready -> FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegDst=1, RegWrite=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1 -> FETCH.
  - ILLEGAL(12): illegal_op=1 -> FETCH. PC has already advanced, so the bad instruction is skipped.
  - Codes 13-15 are unreachable and recover to FETCH.
- Latency with zero memory wait: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles. Each wait cycle in FETCH/MEMRD/MEMWR adds 1.
- Watchdog (TIMEOUT>0):
  - wait_cnt counts consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR. It clears on any state change.
  - On the TIMEOUT-th not-ready cycle: bus_err=1 that cycle, next state FETCH, wait_cnt=0.
  - mem_ready=1 on that same cycle wins: normal completion, no bus_err.
  - Abandoned FETCH leaves PC unchanged, so the re-fetch is the same address. Abandoned MEMRD/MEMWR drops the instruction; no RegWrite is issued.
  - wait_cnt is saturating, width ceil(log2(TIMEOUT+1)).
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction: immediate return to FETCH, all strobes drop asynchronously, no partial write.

Optional Feature:
- MC_RETIRE_CNT_EN defined: adds output instr_retired [CNT_W-1:0], reset to 0.
  - Increments by 1 on leaving MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR-with-mem_ready.
  - Does not count ILLEGAL or watchdog aborts.
  - Wraps from all-ones to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, mem_ready tied 1, stream LW,SW,R,ADDI,BEQ,J -> state_dbg sequences 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,9,10 / 0,1,8 / 0,1,11; control outputs per state exactly as listed.
- FETCH with mem_ready low 3 cycles then high -> IRWrite/PCWrite 0 for 3 cycles, 1 on cycle 4, DECODE next.
- TIMEOUT=4, MEMWR, mem_ready never high -> MemWrite=1 for 4 cycles, bus_err pulse on the 4th, state FETCH, no RegWrite.
- TIMEOUT=4, mem_ready rises on the 4th wait cycle -> no bus_err, normal completion.
- Opcode 6'b111111 in DECODE -> ILLEGAL (12), illegal_op=1 for exactly 1 cycle, then FETCH.
- rst_n low during MEMWB -> RegWrite drops to 0 asynchronously; after release state_dbg=0. With MC_RETIRE_CNT_EN and CNT_W=4: 17 retirements -> instr_retired=1.
